// File: rtl/player_collision_pkg.sv
// Shared constants and types for the player collision probe: tile codes,
// playerCol bit positions, playerState field slices and tile grid geometry.
package player_collision_pkg;

  // Tile grid geometry in screen pixels
  localparam int X0         = 144;
  localparam int Y0         = 35;
  localparam int GRID_W     = 20;
  localparam int GRID_H     = 15;
  localparam int TILE_SHIFT = 5;
  localparam int TILE_PX    = 1 << TILE_SHIFT;
  localparam int PLAYER_W   = 32;
  localparam int PLAYER_H   = 32;

  // playerCol bit positions
  localparam int COL_LEFT  = 0;
  localparam int COL_BOT   = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_TOP   = 3;

  // playerState field slices
  localparam int XPOS_MSB = 31;
  localparam int XPOS_LSB = 22;
  localparam int YPOS_MSB = 21;
  localparam int YPOS_LSB = 12;
  localparam int XSPD_MSB = 11;
  localparam int XSPD_LSB = 7;
  localparam int YSPD_MSB = 6;
  localparam int YSPD_LSB = 2;
  localparam int XDIR_BIT = 1;
  localparam int YDIR_BIT = 0;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_SOLID  = 2'd1,
    TILE_HAZARD = 2'd2,
    TILE_RSVD   = 2'd3
  } tile_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_PROBE_H,
    S_PROBE_V,
    S_PROBE_C,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } point_t;

  typedef struct packed {
    logic [8:0] addr;
    logic       oob_lr;
    logic       oob_top;
    logic       oob_bot;
  } probe_res_t;

  // Side walls read as solid, open sky and the pit below read as empty.
  function automatic tile_e probe_class(input logic oob_lr, input logic oob_top,
                                        input logic oob_bot, input logic [1:0] data);
    tile_e cls;
    if (oob_lr)                 cls = TILE_SOLID;
    else if (oob_top || oob_bot) cls = TILE_EMPTY;
    else begin
      case (data)
        2'd1:    cls = TILE_SOLID;
        2'd2:    cls = TILE_HAZARD;
        default: cls = TILE_EMPTY;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/player_collision_tile_addr_calc.sv
// Maps a signed screen-space probe point to a tile ROM address and flags
// which edge of the grid, if any, the point falls outside of.
module player_collision_tile_addr_calc
  import player_collision_pkg::*;
(
  input  point_t     pt,
  output probe_res_t res
);

  localparam logic signed [12:0] ORG_X     = 13'(X0);
  localparam logic signed [12:0] ORG_Y     = 13'(Y0);
  localparam logic signed [12:0] GRID_PX_W = 13'(GRID_W * TILE_PX);
  localparam logic signed [12:0] GRID_PX_H = 13'(GRID_H * TILE_PX);

  logic signed [12:0] dx;
  logic signed [12:0] dy;
  logic        [4:0]  col;
  logic        [3:0]  row;

  always_comb begin
    dx  = {pt.x[11], pt.x} - ORG_X;
    dy  = {pt.y[11], pt.y} - ORG_Y;
    col = dx[TILE_SHIFT +: 5];
    row = dy[TILE_SHIFT +: 4];

    res.oob_lr  = dx[12] || (dx >= GRID_PX_W);
    res.oob_top = dy[12];
    res.oob_bot = !dy[12] && (dy >= GRID_PX_H);
    // row*20 as (row<<4)+(row<<2), no multiplier needed
    res.addr    = {1'b0, row, 4'b0000} + {3'b000, row, 2'b00} + {4'b0000, col};
  end

endmodule

// File: rtl/player_collision.sv
// Per-tick collision classifier: predicts the player's next box position,
// probes three points against the tile ROM and publishes playerCol/playerKill.
module player_collision
  import player_collision_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] playerState,
  output logic [8:0]  tile_addr,
  input  logic [1:0]  tile_data,
  output logic [3:0]  playerCol,
  output logic        playerKill,
  output logic        col_valid,
  output logic        busy,
  output logic        tick_overrun
);

  state_e      state;
  logic [31:0] st_q;
  point_t      probe_h, probe_v, probe_c;
  logic        pend_lr, pend_top, pend_bot;
  logic [3:0]  col_acc;
  logic        kill_acc;
  logic [8:0]  addr_q;

  logic signed [10:0] nx, ny;
  logic signed [11:0] nx12, ny12;
  point_t      next_h, next_v, next_c, probe_sel;
  probe_res_t  probe_res;
  logic        probe_active;
  tile_e       cur_cls;
  logic        cur_kill;

  // Predicted position and the three probe points, from the latched state
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    probe_sel = '0;
    nx = st_q[XDIR_BIT] ? ({1'b0, st_q[XPOS_MSB:XPOS_LSB]} + {6'b0, st_q[XSPD_MSB:XSPD_LSB]})
                        : ({1'b0, st_q[XPOS_MSB:XPOS_LSB]} - {6'b0, st_q[XSPD_MSB:XSPD_LSB]});
    ny = st_q[YDIR_BIT] ? ({1'b0, st_q[YPOS_MSB:YPOS_LSB]} - {6'b0, st_q[YSPD_MSB:YSPD_LSB]})
                        : ({1'b0, st_q[YPOS_MSB:YPOS_LSB]} + {6'b0, st_q[YSPD_MSB:YSPD_LSB]});
    nx12 = {nx[10], nx};
    ny12 = {ny[10], ny};

    next_h.x = st_q[XDIR_BIT] ? nx12 + 12'(PLAYER_W - 1) : nx12;
    next_h.y = ny12 + 12'(PLAYER_H / 2);
    next_v.x = nx12 + 12'(PLAYER_W / 2);
    // Downward probe sits one pixel below the feet so standing reports bottom.
    next_v.y = st_q[YDIR_BIT] ? ny12 : ny12 + 12'(PLAYER_H);
    next_c.x = nx12 + 12'(PLAYER_W / 2);
    next_c.y = ny12 + 12'(PLAYER_H / 2);

    case (state)
      S_PROBE_H: probe_sel = probe_h;
      S_PROBE_V: probe_sel = probe_v;
      S_PROBE_C: probe_sel = probe_c;
      default:   probe_sel = '0;
    endcase
  end

  player_collision_tile_addr_calc u_tile_addr_calc (
    .pt  (probe_sel),
    .res (probe_res)
  );

  // Off-grid probes leave the ROM address where it was
  always_comb begin
    probe_active = (state == S_PROBE_H) || (state == S_PROBE_V) || (state == S_PROBE_C);
    tile_addr    = addr_q;
    if (probe_active && !(probe_res.oob_lr || probe_res.oob_top || probe_res.oob_bot))
      tile_addr = probe_res.addr;
    cur_cls  = probe_class(pend_lr, pend_top, pend_bot, tile_data);
    cur_kill = (cur_cls == TILE_HAZARD) || pend_bot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register, datapath included, is reset so a mid-evaluation abort leaves no stale state.
      state        <= S_IDLE;
      st_q         <= '0;
      probe_h      <= '0;
      probe_v      <= '0;
      probe_c      <= '0;
      pend_lr      <= 1'b0;
      pend_top     <= 1'b0;
      pend_bot     <= 1'b0;
      col_acc      <= '0;
      kill_acc     <= 1'b0;
      addr_q       <= '0;
      playerCol    <= '0;
      playerKill   <= 1'b0;
      col_valid    <= 1'b0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      col_valid <= 1'b0;
      addr_q    <= tile_addr;
      if (frame_tick && (state != S_IDLE))
        tick_overrun <= 1'b1;
      if (probe_active) begin
        pend_lr  <= probe_res.oob_lr;
        pend_top <= probe_res.oob_top;
        pend_bot <= probe_res.oob_bot;
      end

      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            st_q  <= playerState;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          probe_h  <= next_h;
          probe_v  <= next_v;
          probe_c  <= next_c;
          col_acc  <= '0;
          kill_acc <= 1'b0;
          state    <= S_PROBE_H;
        end
        S_PROBE_H: state <= S_PROBE_V;
        S_PROBE_V: begin
          // Horizontal probe result arrives here
          if (cur_cls == TILE_SOLID)
            col_acc[st_q[XDIR_BIT] ? COL_RIGHT : COL_LEFT] <= 1'b1;
          kill_acc <= kill_acc | cur_kill;
          state    <= S_PROBE_C;
        end
        S_PROBE_C: begin
          if (cur_cls == TILE_SOLID)
            col_acc[st_q[YDIR_BIT] ? COL_TOP : COL_BOT] <= 1'b1;
          kill_acc <= kill_acc | cur_kill;
          state    <= S_DRAIN;
        end
        S_DRAIN: begin
          // Centre probe only contributes to kill
          playerCol  <= col_acc;
          playerKill <= kill_acc | cur_kill;
          col_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
